// File: rtl/tlb_refill.sv
// tlb_refill: refill / invalidate engine and sole writer of the TLB CAM.
// A lookup miss walks a single-level page table over a valid/ready memory
// port and installs the VPN->PFN pair into a round-robin victim entry. A flush
// request sweeps every entry invalid, one entry per cycle in ascending order.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both high
// at the rising edge. A valid, once raised, stays high with stable payload
// until it is accepted. miss_ready and the response side (always ready in WAIT)
// belong to this block; mem_req_ready belongs to the memory.
module tlb_refill #(
  parameter int ENTRIES = 64,
  parameter int VPN_W   = 34,
  parameter int PFN_W   = 26,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_valid,
  input  logic [VPN_W-1:0] miss_vpn,
  output logic             miss_ready,
  input  logic [63:0]      ptbr,
  input  logic             flush,
  output logic             mem_req_valid,
  output logic [63:0]      mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  input  logic [63:0]      mem_resp_data,
  input  logic             mem_resp_err,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_widx,
  output logic [VPN_W-1:0] tlb_wvpn,
  output logic [PFN_W-1:0] tlb_wpfn,
  output logic             tlb_wvalid,
  output logic             done_valid,
  output logic             done_fault,
  output logic             flush_busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sweep_cnt;
  logic             flush_pend;
  logic [VPN_W-1:0] vpn_q;
  logic [63:0]      addr_q;
  logic [PFN_W-1:0] pfn_q;
  logic             fault_q;
  logic             wr_ok;

  // PTE bits outside V and PFN carry nothing this engine uses.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{mem_resp_data[63:10+PFN_W], mem_resp_data[9:1]};

  // Walk / sweep sequencer; all datapath registers live here with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      sweep_cnt  <= '0;
      flush_pend <= 1'b0;
      vpn_q      <= '0;
      addr_q     <= '0;
      pfn_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A flush (live or remembered) always beats a concurrent miss.
          if (flush || flush_pend) begin
            sweep_cnt <= '0;
            state     <= S_FLUSH;
          end else if (miss_valid) begin
            vpn_q  <= miss_vpn;
            addr_q <= ptbr + 64'({miss_vpn, 3'b000});
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_resp_valid) begin
            pfn_q   <= mem_resp_data[10 +: PFN_W];
            fault_q <= mem_resp_err | ~mem_resp_data[0];
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (flush) flush_pend <= 1'b1;
          // Victim pointer only advances when an entry was really installed.
          if (!fault_q) rr_ptr <= rr_ptr + 1'b1;
          state <= S_IDLE;
        end
        S_FLUSH: begin
          // Flush requests here are deliberately ignored: no restart.
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == IDX_W'(ENTRIES - 1)) begin
            rr_ptr     <= '0;
            flush_pend <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decodes of registered state; only miss_ready looks at live inputs.
  always_comb begin
    wr_ok         = (state == S_WRITE) && !fault_q;
    miss_ready    = (state == S_IDLE) && !flush_pend && !flush && !rst;
    mem_req_valid = (state == S_REQ);
    mem_req_addr  = (state == S_REQ) ? addr_q : '0;
    tlb_we        = wr_ok || (state == S_FLUSH);
    tlb_widx      = (state == S_FLUSH) ? sweep_cnt : (wr_ok ? rr_ptr : '0);
    tlb_wvpn      = wr_ok ? vpn_q : '0;
    tlb_wpfn      = wr_ok ? pfn_q : '0;
    tlb_wvalid    = wr_ok;
    done_valid    = (state == S_WRITE);
    done_fault    = (state == S_WRITE) && fault_q;
    flush_busy    = (state == S_FLUSH);
    dbg_state     = state;
  end

endmodule

// File: tb/tb_tlb_refill.sv
// Directed bench for tlb_refill: a vector table of page walks plus hand-written
// sequences for round-robin wrap, flush sweeps, flush during a walk and reset
// mid-walk. Inputs change and outputs are sampled on the falling clock edge.
module tb_tlb_refill;

  logic        clk;
  logic        rst;
  logic        miss_valid;
  logic [33:0] miss_vpn;
  logic        miss_ready;
  logic [63:0] ptbr;
  logic        flush;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        mem_resp_err;
  logic        tlb_we;
  logic [5:0]  tlb_widx;
  logic [33:0] tlb_wvpn;
  logic [25:0] tlb_wpfn;
  logic        tlb_wvalid;
  logic        done_valid;
  logic        done_fault;
  logic        flush_busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [33:0] vpn;
    logic [63:0] ptbr;
    logic [63:0] data;
    logic        err;
    int          req_stall;
    int          resp_delay;
    logic [63:0] exp_addr;
    logic        exp_fault;
    logic [5:0]  exp_idx;
    logic [25:0] exp_pfn;
  } vec_t;

  vec_t vecs[6];

  tlb_refill dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_ready(miss_ready),
    .ptbr(ptbr), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wvpn(tlb_wvpn),
    .tlb_wpfn(tlb_wpfn), .tlb_wvalid(tlb_wvalid),
    .done_valid(done_valid), .done_fault(done_fault),
    .flush_busy(flush_busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Full walk from IDLE; checks request, stalls, write pulse and return to IDLE.
  task automatic do_walk(input logic [33:0] vpn, input logic [63:0] base,
                         input logic [63:0] data, input logic err,
                         input int req_stall, input int resp_delay,
                         input logic [63:0] exp_addr, input logic exp_fault,
                         input logic [5:0] exp_idx, input logic [25:0] exp_pfn);
    @(negedge clk);
    chk("ready_before_miss", miss_ready, 1);
    miss_valid = 1'b1;
    miss_vpn   = vpn;
    ptbr       = base;
    @(negedge clk);
    miss_valid = 1'b0;
    miss_vpn   = '0;
    ptbr       = '0;
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, exp_addr);
    for (int i = 0; i < req_stall; i++) begin
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("req_valid_stall", mem_req_valid, 1);
      chk("req_addr_stall", mem_req_addr, exp_addr);
      chk("ready_in_req", miss_ready, 0);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("req_dropped", mem_req_valid, 0);
    for (int i = 0; i < resp_delay; i++) begin
      @(negedge clk);
      chk("we_in_wait", tlb_we, 0);
      chk("done_in_wait", done_valid, 0);
      chk("ready_in_wait", miss_ready, 0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    mem_resp_err   = err;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    chk("done_valid", done_valid, 1);
    chk("done_fault", done_fault, exp_fault);
    chk("tlb_we", tlb_we, !exp_fault);
    chk("tlb_wvalid", tlb_wvalid, !exp_fault);
    if (!exp_fault) begin
      chk("tlb_widx", tlb_widx, exp_idx);
      chk("tlb_wvpn", tlb_wvpn, vpn);
      chk("tlb_wpfn", tlb_wpfn, exp_pfn);
    end
    @(negedge clk);
    chk("we_after", tlb_we, 0);
    chk("done_after", done_valid, 0);
    chk("ready_after", miss_ready, 1);
  endtask

  // Checks a full 64-entry sweep whose first write is visible at this negedge.
  task automatic check_sweep(input int pulse_at);
    logic [63:0] exp_idx;
    for (int i = 0; i < 64; i++) exp_q.push_back(64'(i));
    for (int i = 0; i < 64; i++) begin
      exp_idx = exp_q.pop_front();
      chk("sweep_we", tlb_we, 1);
      chk("sweep_idx", tlb_widx, exp_idx);
      chk("sweep_wvalid", tlb_wvalid, 0);
      chk("sweep_vpn_pfn", {tlb_wvpn, tlb_wpfn}, 0);
      chk("sweep_busy", flush_busy, 1);
      chk("sweep_ready", miss_ready, 0);
      flush = (i == pulse_at);
      @(negedge clk);
    end
    flush = 1'b0;
    chk("sweep_end_we", tlb_we, 0);
    chk("sweep_end_busy", flush_busy, 0);
    chk("sweep_end_ready", miss_ready, 1);
  endtask

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_vpn = '0; ptbr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    mem_resp_err = 1'b0;

    vecs[0] = '{vpn: 34'h0_0000_0005, ptbr: 64'h1000, data: 64'h0000_0000_0001_2401,
                err: 1'b0, req_stall: 0, resp_delay: 0, exp_addr: 64'h1028,
                exp_fault: 1'b0, exp_idx: 6'd0, exp_pfn: 26'h49};
    vecs[1] = '{vpn: 34'h3_FFFF_FFFF, ptbr: 64'hFFFF_FFFF_FFFF_F000,
                data: 64'h0000_000F_FFFF_FC01, err: 1'b0, req_stall: 0, resp_delay: 0,
                exp_addr: 64'h0000_001F_FFFF_EFF8, exp_fault: 1'b0, exp_idx: 6'd1,
                exp_pfn: 26'h3FF_FFFF};
    vecs[2] = '{vpn: 34'h10, ptbr: 64'h0, data: 64'h12400, err: 1'b0,
                req_stall: 0, resp_delay: 0, exp_addr: 64'h80, exp_fault: 1'b1,
                exp_idx: 6'd2, exp_pfn: 26'h0};
    vecs[3] = '{vpn: 34'h20, ptbr: 64'h100, data: 64'h401, err: 1'b1,
                req_stall: 0, resp_delay: 0, exp_addr: 64'h200, exp_fault: 1'b1,
                exp_idx: 6'd2, exp_pfn: 26'h0};
    vecs[4] = '{vpn: 34'h2_AAAA_5555, ptbr: 64'h8000_0000_0000_0000,
                data: 64'hFFFF_FFF0_0000_0C01, err: 1'b0, req_stall: 0, resp_delay: 0,
                exp_addr: 64'h8000_0015_5552_AAA8, exp_fault: 1'b0, exp_idx: 6'd2,
                exp_pfn: 26'h3};
    vecs[5] = '{vpn: 34'h7, ptbr: 64'h40, data: 64'h401, err: 1'b0,
                req_stall: 5, resp_delay: 3, exp_addr: 64'h78, exp_fault: 1'b0,
                exp_idx: 6'd3, exp_pfn: 26'h1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", miss_ready, 0);
    chk("rst_we", tlb_we, 0);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_busy", flush_busy, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", miss_ready, 1);

    // Vector table: basic refill, address wrap, both fault kinds, stalls
    for (int v = 0; v < 6; v++)
      do_walk(vecs[v].vpn, vecs[v].ptbr, vecs[v].data, vecs[v].err,
              vecs[v].req_stall, vecs[v].resp_delay, vecs[v].exp_addr,
              vecs[v].exp_fault, vecs[v].exp_idx, vecs[v].exp_pfn);

    // Round-robin: indices 4..63 then wrap to 0
    for (int i = 4; i <= 64; i++)
      do_walk(34'(i), 64'h0, (64'(i) << 10) | 64'h1, 1'b0, 0, 0,
              64'(i) << 3, 1'b0, 6'(i % 64), 26'(i));

    // Flush in IDLE beats a concurrent miss; second flush mid-sweep ignored
    @(negedge clk);
    flush = 1'b1;
    miss_valid = 1'b1;
    miss_vpn = 34'h55;
    #1;
    chk("flush_blocks_ready", miss_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    miss_valid = 1'b0;
    chk("flush_no_req", mem_req_valid, 0);
    check_sweep(20);
    chk("no_req_after_flush", mem_req_valid, 0);
    do_walk(34'h11, 64'h0, 64'h801, 1'b0, 0, 0, 64'h88, 1'b0, 6'd0, 26'h2);

    // Flush pulse while waiting on memory: write first, then sweep
    @(negedge clk);
    miss_valid = 1'b1; miss_vpn = 34'h33; ptbr = 64'h0;
    @(negedge clk);
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hC01;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    chk("fw_we", tlb_we, 1);
    chk("fw_idx", tlb_widx, 1);
    chk("fw_pfn", tlb_wpfn, 3);
    chk("fw_done", done_valid, 1);
    @(negedge clk);
    chk("fw_idle_we", tlb_we, 0);
    chk("fw_idle_ready", miss_ready, 0);
    chk("fw_idle_busy", flush_busy, 0);
    @(negedge clk);
    check_sweep(-1);
    do_walk(34'h12, 64'h0, 64'h401, 1'b0, 0, 0, 64'h90, 1'b0, 6'd0, 26'h1);

    // Reset mid-walk, then a stray response
    @(negedge clk);
    miss_valid = 1'b1; miss_vpn = 34'h44; ptbr = 64'h0;
    @(negedge clk);
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mr_rst_ready", miss_ready, 0);
    chk("mr_rst_we", tlb_we, 0);
    chk("mr_rst_done", done_valid, 0);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h401;
    #1;
    chk("mr_ready", miss_ready, 1);
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    chk("mr_stray_we", tlb_we, 0);
    chk("mr_stray_done", done_valid, 0);
    chk("mr_stray_req", mem_req_valid, 0);
    do_walk(34'h13, 64'h0, 64'h1401, 1'b0, 0, 0, 64'h98, 1'b0, 6'd0, 26'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tlb_refill.md
# tlb_refill

Refill and invalidate engine that writes the 64-entry TLB CAM. On a lookup miss it fetches a single-level page-table entry over a valid/ready memory port and writes the VPN→PFN pair into a victim entry chosen round-robin. It also sweeps every entry invalid on a flush request. It sits between the core's miss path and the CAM's write port, and is the only writer of CAM contents.

## Interface
- ENTRIES, 64, number of CAM entries; power of two.
- VPN_W, 34, virtual page number width.
- PFN_W, 26, physical frame number width.
- IDX_W, 6, log2(ENTRIES).
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- miss_valid  in  1  miss request.
- miss_vpn  in  VPN_W  missing VPN.
- miss_ready  out  1  engine can accept a miss; high only in IDLE with no flush pending or present.
- ptbr  in  64  page-table base byte address; sampled at miss acceptance.
- flush  in  1  invalidate-all request, level-sensitive, sampled each cycle.
- mem_req_valid  out  1  PTE read request.
- mem_req_addr  out  64  PTE byte address = ptbr + {miss_vpn, 3'b000}, modulo 2^64.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  PTE data valid; engine always ready in WAIT.
- mem_resp_data  in  64  PTE; bit 0 = V, bits [35:10] = PFN.
- mem_resp_err  in  1  bus error for this response.
- tlb_we  out  1  CAM write strobe.
- tlb_widx  out  IDX_W  entry index written.
- tlb_wvpn  out  VPN_W  tag written.
- tlb_wpfn  out  PFN_W  frame written.
- tlb_wvalid  out  1  valid bit written.
- done_valid  out  1  one-cycle pulse: the walk finished.
- done_fault  out  1  qualifies done_valid; 1 = page fault or bus error.
- flush_busy  out  1  high while a sweep is in progress.

## Operation
- States are IDLE, REQ, WAIT, WRITE and FLUSH.
- **IDLE**
  - If flush or a pending flush is present, go to FLUSH. Flush wins over a simultaneous miss_valid, and miss_ready=0 that cycle.
  - Otherwise, when miss_valid & miss_ready, latch miss_vpn and ptbr and go to REQ.
- **REQ**
  - mem_req_valid=1, with mem_req_addr stable until mem_req_ready.
  - On handshake, go to WAIT.
- **WAIT**
  - On mem_resp_valid, latch data and err, and set fault = err | ~data[0].
  - Go to WRITE.
- **WRITE** (one cycle)
  - done_valid=1 and done_fault=fault.
  - If no fault:
    - Drive tlb_we=1, tlb_widx=rr_ptr, tlb_wvpn=latched VPN, tlb_wpfn=data[35:10] and tlb_wvalid=1.
    - Then rr_ptr increments, wrapping ENTRIES-1→0.
  - If fault: tlb_we=0 and rr_ptr is unchanged.
  - Go to IDLE.
- **FLUSH**
  - A 6-bit sweep counter runs 0..ENTRIES-1.
  - Every cycle drives tlb_we=1, tlb_widx=counter, tlb_wvalid=0 and tlb_wvpn/tlb_wpfn=0.
  - flush_busy=1.
  - After index ENTRIES-1 is written: rr_ptr←0, pending flush cleared, go to IDLE.
- **Flush asserted in REQ/WAIT/WRITE**
  - Sets the pending flag; the walk completes normally, including its write.
  - The sweep runs from IDLE on the next cycle.
- Flush asserted during FLUSH is ignored and does not restart the sweep.
- mem_resp_valid outside WAIT is ignored.
- **Reset**
  - State is IDLE and rr_ptr=0; the pending flag and sweep counter are cleared.
  - All outputs are 0: miss_ready=0 in the reset cycle, then 1 from the first cycle after reset deassertion.
  - Reset mid-walk abandons the request, and any response that arrives later is ignored.

## Timing
- All outputs are registered-state decodes; there is no combinational path from any input to any output except miss_ready, which depends on flush.
- Miss accepted at cycle T:
  - mem_req_valid rises at T+1.
  - With ready at T+1 and response at T+2, the WRITE pulse (tlb_we, done_valid) is at T+3.
  - miss_ready is high again at T+4.
  - This is the minimum of 4 cycles between accepted misses.
- Each memory stall cycle adds one cycle. mem_req_valid never drops before mem_req_ready.
- A flush takes exactly ENTRIES cycles of tlb_we=1 with indices ascending. miss_ready returns the cycle after index 63.
- done_valid and tlb_we are single-cycle pulses; at most one CAM write occurs per cycle.

## Test plan
- **Basic refill after reset:** miss_vpn=0x0_0000_0005, ptbr=0x1000 → mem_req_addr=0x1028; response data=0x0000_0000_0001_2401 → tlb_we pulse with idx 0, vpn 0x5, pfn 0x49 and valid 1; done_valid=1, done_fault=0.
- **Round-robin wrap:** 65 successful refills → indices 0..63 then 0. A faulting response (data bit0=0) between refills gives done_fault=1, no tlb_we, and the next successful write reuses the same index. mem_resp_err=1 with V=1 behaves the same.
- **Memory stalls:** hold mem_req_ready=0 for 5 cycles → address stable and valid held. Delay the response 3 cycles → WRITE occurs 3 cycles later, and miss_ready stays 0 throughout.
- **Flush:** flush in IDLE concurrent with miss_valid → miss not accepted; 64 writes with idx 0..63, wvalid=0, flush_busy=1. Afterwards the first refill writes idx 0.
- **Flush during walk:** flush pulse in WAIT → the walk's write occurs first, then the sweep starts the next cycle. A second flush pulse mid-sweep produces no extra writes.
- **Reset mid-walk:** rst in WAIT, then a stray mem_resp_valid → no tlb_we and no done_valid; miss_ready=1 after reset; rr_ptr restarts at 0.
